instruction_queue: RTL
======================

# instruction_queue

Parametrised successor of the dual-issue instruction FIFO: buffers fetched instructions with their PCs between fetch and decode. It accepts up to WRITE_PORTS and presents up to READ_PORTS entries per cycle at configurable depth and widths. On a branch-redirect flush it preserves the delay-slot instruction, including when that instruction has not yet arrived from fetch.

## Interface
- DEPTH, 16: entries; power of two, ≥ 2·max(WRITE_PORTS, READ_PORTS)
- WRITE_PORTS, 2: fetch lanes per cycle
- READ_PORTS, 2: issue lanes per cycle
- DATA_W, 32: instruction width
- ADDR_W, 32: PC width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_valid  in  WRITE_PORTS  per-lane write valid; contiguous from lane 0
- wr_data  in  WRITE_PORTS×DATA_W  instructions
- wr_addr  in  WRITE_PORTS×ADDR_W  PCs
- rd_cnt  in  $clog2(READ_PORTS+1)  entries consumed this cycle
- flush  in  1  discard all queued entries
- flush_ds  in  1  with flush: keep the delay-slot instruction
- rd_valid  out  READ_PORTS  per-lane output valid; contiguous
- rd_data  out  READ_PORTS×DATA_W  instructions; 0 on invalid lanes
- rd_addr  out  READ_PORTS×ADDR_W  PCs; 0 on invalid lanes
- rd_ds  out  1  lane 0 is a preserved delay slot
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  DEPTH − count < WRITE_PORTS
- overflow  out  1  sticky; a write group was dropped

## Operation
- Circular buffer with $clog2(DEPTH)-bit read and write pointers. Pointers wrap modulo DEPTH.
- count is DEPTH+1-valued. It updates as count + pushes − pops.
- Write:
  - pushes = popcount(wr_valid).
  - Lane i writes slot wr_ptr+i.
  - A group is accepted whole only if pushes ≤ DEPTH − count, judged on pre-pop count with no same-cycle pass-through.
  - Otherwise the whole group is dropped and overflow is set. It clears only on reset.
- Read:
  - rd_valid[i] = (i < count) in NORMAL state.
  - pops = min(rd_cnt, valid lanes); excess is ignored.
  - rd_ptr advances by pops.
- FSM states: NORMAL, DS_WAIT, DS_HOLD.
  - NORMAL, flush without flush_ds: clear pointers and count; drop this cycle's writes; stay NORMAL.
  - NORMAL, flush with flush_ds: clear the queue. The delay-slot candidate is the entry at rd_ptr+pops.
    - If count > pops, copy that entry into the hold register → DS_HOLD.
    - Else if wr_valid[0], capture wr lane 0 → DS_HOLD.
    - Else → DS_WAIT.
    - All other writes in this cycle are dropped.
  - DS_WAIT: all rd_valid = 0. First cycle with wr_valid[0]: capture lane 0 into hold, drop lanes ≥1 → DS_HOLD.
  - DS_HOLD:
    - Outputs: rd_valid = 1 on lane 0 only, showing the hold register; rd_ds = 1.
    - Writes enter the queue normally.
    - rd_cnt ≥ 1 → NORMAL; only the held entry is consumed.
  - flush in DS_WAIT or DS_HOLD: hold discarded; then same as from NORMAL with queue candidate only. A flush_ds here → DS_WAIT unless wr_valid[0].
- Reset: NORMAL, pointers 0, count 0, hold 0, overflow 0.

## Timing
- Write-to-read latency is 1 cycle; an entry written in cycle N is visible in N+1.
- Outputs are combinational from registered state only. There is no combinational path from wr_* to rd_*.
- rd_cnt is sampled the same cycle as rd_valid; consumption takes effect at the edge.
- Reset values: rd_valid 0, rd_data/rd_addr 0, rd_ds 0, count 0, empty 1, full 0, overflow 0.
- Reset dominates flush, which dominates reads and writes.

## Configuration
- INSTR_QUEUE_DELAY_SLOT_EN defined: FSM, hold register and rd_ds are present as above.
- Undefined:
  - flush_ds is ignored and every flush is a plain clear.
  - rd_ds is tied 0.
  - FSM and hold register are removed.

## Structure
- Shared package instr_queue_pkg holds:
  - typedef iq_entry_t {data, addr};
  - enum iq_state_e {IQ_NORMAL, IQ_DS_WAIT, IQ_HOLD};
  - helper constant functions for pointer/count widths.
- Sub-module instr_queue_storage: DEPTH-entry register array with WRITE_PORTS write ports and READ_PORTS combinational read ports at base+i modulo DEPTH.

## Test plan
- Fill/drain, defaults: write 2/cycle for 8 cycles, no reads → count 16, full 1 from count 15. Next group dropped; overflow = 1.
- Wrap-around: 40 cycles of 2 writes and 2 reads after preloading 3 → every output PC is strictly sequential across pointer wrap; count steady at 3.
- Odd occupancy: count 1, rd_cnt 2 → only lane 0 valid, pops 1, count 0, empty 1; rd_data[1] = 0.
- Flush with delay slot in queue: entries PC 0x100..0x10C, rd_cnt 1, flush+flush_ds → next cycle lane 0 = 0x104, rd_ds 1, count 0. rd_cnt 1 → NORMAL.
- Flush with delay slot not yet fetched: count 1, rd_cnt 1, flush+flush_ds, no write → DS_WAIT with rd_valid 0 for 3 cycles. Write 0x200/0x204 → only 0x200 held with rd_ds 1; 0x204 is dropped.
- Macro off: same stimulus as the previous scenario → queue cleared, rd_ds 0, the following write appears normally next cycle.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// -----------------------------------------------------------------------------
// instr_queue_pkg
// Shared types and width helpers for the instruction queue slice.
//   iq_entry_t  : one queue entry (instruction word + PC) at the default widths
//   iq_state_e  : delay-slot flush state machine encoding
//   iq_ptr_w    : pointer width for a given depth
//   iq_cnt_w    : occupancy counter width (holds 0..DEPTH)
//   iq_rdcnt_w  : width of a "lanes consumed" field for a given lane count
// -----------------------------------------------------------------------------
package instr_queue_pkg;

    localparam int unsigned IQ_DATA_W = 32;
    localparam int unsigned IQ_ADDR_W = 32;

    typedef struct packed {
        logic [IQ_DATA_W-1:0] data;
        logic [IQ_ADDR_W-1:0] addr;
    } iq_entry_t;

    typedef enum logic [1:0] {
        IQ_NORMAL,
        IQ_DS_WAIT,
        IQ_HOLD
    } iq_state_e;

    function automatic int unsigned iq_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned iq_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned iq_rdcnt_w(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/instr_queue_storage.sv
// -----------------------------------------------------------------------------
// instr_queue_storage
// DEPTH-entry register array holding instruction words and their PCs.
// Ports:
//   clk      : clock, writes on rising edge
//   wr_en    : per-lane write enable; lane i writes slot wr_base+i (mod DEPTH)
//   wr_base  : first slot written this cycle
//   wr_data  : WRITE_PORTS instruction words, lane 0 in the low bits
//   wr_addr  : WRITE_PORTS PCs, lane 0 in the low bits
//   rd_base  : first slot read
//   rd_data  : NUM_RD combinational read lanes at rd_base+i (mod DEPTH)
//   rd_addr  : matching PCs
// The array itself carries no reset; validity is tracked by the owner.
// -----------------------------------------------------------------------------
module instr_queue_storage
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                       clk,
    input  logic [WRITE_PORTS-1:0]     wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  logic [WRITE_PORTS*DATA_W-1:0] wr_data,
    input  logic [WRITE_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD*ADDR_W-1:0]   rd_addr
);

    localparam int unsigned PTR_W = iq_ptr_w(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];

    // Index sums are PTR_W wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
            if (wr_en[i]) begin
                mem_data[wr_base + PTR_W'(i)] <= wr_data[i*DATA_W +: DATA_W];
                mem_addr[wr_base + PTR_W'(i)] <= wr_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_addr = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = mem_data[rd_base + PTR_W'(i)];
            rd_addr[i*ADDR_W +: ADDR_W] = mem_addr[rd_base + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
// Multi-lane instruction FIFO between fetch and decode, with optional
// delay-slot preservation across branch-redirect flushes.
// Build option: define INSTR_QUEUE_DELAY_SLOT_EN to include the delay-slot
// state machine, hold register and rd_ds; otherwise every flush is a plain
// clear and rd_ds is tied low.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   wr_valid   : per-lane write valid (contiguous from lane 0)
//   wr_data    : instructions, lane 0 in the low bits
//   wr_addr    : PCs, lane 0 in the low bits
//   rd_cnt     : entries consumed this cycle (clipped to visible lanes)
//   flush      : discard all queued entries
//   flush_ds   : with flush, keep the delay-slot instruction
//   rd_valid   : per-lane output valid (contiguous)
//   rd_data    : instructions, zero on invalid lanes
//   rd_addr    : PCs, zero on invalid lanes
//   rd_ds      : lane 0 is a preserved delay slot
//   count      : occupied queue entries (hold register not included)
//   empty/full : count == 0 / fewer than WRITE_PORTS free slots
//   overflow   : sticky, set when a write group was dropped
// -----------------------------------------------------------------------------
module instruction_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WRITE_PORTS-1:0]           wr_valid,
    input  logic [WRITE_PORTS*DATA_W-1:0]    wr_data,
    input  logic [WRITE_PORTS*ADDR_W-1:0]    wr_addr,
    input  logic [$clog2(READ_PORTS+1)-1:0]  rd_cnt,
    input  logic                             flush,
    input  logic                             flush_ds,
    output logic [READ_PORTS-1:0]            rd_valid,
    output logic [READ_PORTS*DATA_W-1:0]     rd_data,
    output logic [READ_PORTS*ADDR_W-1:0]     rd_addr,
    output logic                             rd_ds,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             empty,
    output logic                             full,
    output logic                             overflow
);

    localparam int unsigned PTR_W = iq_ptr_w(DEPTH);
    localparam int unsigned CNT_W = iq_cnt_w(DEPTH);

`ifdef INSTR_QUEUE_DELAY_SLOT_EN
    // One extra read lane exposes the entry just past the consumed ones,
    // which is the delay-slot candidate when all visible lanes are popped.
    localparam int unsigned NUM_RD = READ_PORTS + 1;
`else
    localparam int unsigned NUM_RD = READ_PORTS;
`endif

    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [CNT_W-1:0]           pushes;
    logic [CNT_W-1:0]           avail;
    logic [CNT_W-1:0]           vis;
    logic [CNT_W-1:0]           rc_ext;
    logic [CNT_W-1:0]           pops;
    logic                       fits;
    logic                       accept;
    logic                       drop;
    logic                       in_wait;
    logic                       in_normal;
    logic [WRITE_PORTS-1:0]     st_wr_en;
    logic [NUM_RD*DATA_W-1:0]   st_rd_data;
    logic [NUM_RD*ADDR_W-1:0]   st_rd_addr;

    instr_queue_storage #(
        .DEPTH       (DEPTH),
        .WRITE_PORTS (WRITE_PORTS),
        .NUM_RD      (NUM_RD),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (st_wr_en),
        .wr_base (wr_ptr),
        .wr_data (wr_data),
        .wr_addr (wr_addr),
        .rd_base (rd_ptr),
        .rd_data (st_rd_data),
        .rd_addr (st_rd_addr)
    );

    always_comb begin
        pushes = '0;
        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
            pushes = pushes + CNT_W'(wr_valid[i]);
        end
    end

    // Acceptance uses the pre-pop occupancy: no same-cycle pass-through.
    assign avail  = CNT_W'(DEPTH) - count;
    assign fits   = (pushes <= avail);
    assign accept = (pushes != '0) && fits && !in_wait;
    assign drop   = (pushes != '0) && !fits && !in_wait;

    assign vis    = in_normal ? ((count < CNT_W'(READ_PORTS)) ? count : CNT_W'(READ_PORTS)) : '0;
    assign rc_ext = CNT_W'(rd_cnt);
    assign pops   = (rc_ext < vis) ? rc_ext : vis;

    assign st_wr_en = (rst_n && !flush && accept) ? wr_valid : '0;

    assign empty = (count == '0);
    assign full  = (avail < CNT_W'(WRITE_PORTS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pops);
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(pushes);
                count  <= count + pushes - pops;
            end else begin
                count  <= count - pops;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef INSTR_QUEUE_DELAY_SLOT_EN
    iq_state_e          state;
    logic [DATA_W-1:0]  hold_data;
    logic [ADDR_W-1:0]  hold_addr;
    logic [DATA_W-1:0]  cand_data;
    logic [ADDR_W-1:0]  cand_addr;

    assign in_wait   = (state == IQ_DS_WAIT);
    assign in_normal = (state == IQ_NORMAL);
    assign cand_data = st_rd_data[int'(pops)*DATA_W +: DATA_W];
    assign cand_addr = st_rd_addr[int'(pops)*ADDR_W +: ADDR_W];

    // Outside NORMAL no queue lane is visible, so pops is 0 and the
    // candidate on a flush is simply the queue head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IQ_NORMAL;
            hold_data <= '0;
            hold_addr <= '0;
        end else if (flush) begin
            hold_data <= '0;
            hold_addr <= '0;
            if (!flush_ds) begin
                state <= IQ_NORMAL;
            end else if (count > pops) begin
                hold_data <= cand_data;
                hold_addr <= cand_addr;
                state     <= IQ_HOLD;
            end else if (wr_valid[0]) begin
                hold_data <= wr_data[DATA_W-1:0];
                hold_addr <= wr_addr[ADDR_W-1:0];
                state     <= IQ_HOLD;
            end else begin
                state <= IQ_DS_WAIT;
            end
        end else begin
            case (state)
                IQ_DS_WAIT: begin
                    if (wr_valid[0]) begin
                        hold_data <= wr_data[DATA_W-1:0];
                        hold_addr <= wr_addr[ADDR_W-1:0];
                        state     <= IQ_HOLD;
                    end
                end
                IQ_HOLD: begin
                    if (rd_cnt != '0) begin
                        state <= IQ_NORMAL;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end
`else
    logic unused_flush_ds;

    assign unused_flush_ds = flush_ds;
    assign in_wait         = 1'b0;
    assign in_normal       = 1'b1;
`endif

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        rd_addr  = '0;
        rd_ds    = 1'b0;
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            if (CNT_W'(i) < vis) begin
                rd_valid[i]                 = 1'b1;
                rd_data[i*DATA_W +: DATA_W] = st_rd_data[i*DATA_W +: DATA_W];
                rd_addr[i*ADDR_W +: ADDR_W] = st_rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
`ifdef INSTR_QUEUE_DELAY_SLOT_EN
        if (state == IQ_HOLD) begin
            rd_valid[0]          = 1'b1;
            rd_data[DATA_W-1:0]  = hold_data;
            rd_addr[ADDR_W-1:0]  = hold_addr;
            rd_ds                = 1'b1;
        end
`endif
    end

endmodule
